reg_dump_scanner: RTL

//  Reader side of the register file debug port: on a start pulse, walks reg_sel across a register range,

---
 rtl/reg_dump_scanner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/reg_dump_scanner.sv
// Walks reg_sel over FIRST_REG..LAST_REG, samples reg_data and streams each word on valid/ready.
// Optional feature macro REGDUMP_CHKSUM_EN appends an XOR checksum word tagged out_idx 6'h20.
module reg_dump_scanner #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad_range
        $error("reg_dump_scanner: require 0 <= FIRST_REG <= LAST_REG <= 31");
    end
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("reg_dump_scanner: SETTLE must be 1..15");
    end

    localparam logic [4:0] FIRST_SEL = 5'(FIRST_REG);
    localparam logic [4:0] LAST_SEL  = 5'(LAST_REG);
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

`ifdef REGDUMP_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, SEL, CAP, HOLD, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEL, CAP, HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  reg_sel_q, reg_sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_data_q, out_data_d;
    logic [5:0]  out_idx_q, out_idx_d;
    logic        out_last_q, out_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef REGDUMP_CHKSUM_EN
    logic [31:0] chksum_q, chksum_d;
`endif

    always_comb begin
        state_d     = state_q;
        reg_sel_d   = reg_sel_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef REGDUMP_CHKSUM_EN
        chksum_d    = chksum_q;
`endif
        // abort outranks start and any pending handshake; reg_sel is left where it was
        if (abort) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        reg_sel_d = FIRST_SEL;
                        cnt_d     = SETTLE_LD;
`ifdef REGDUMP_CHKSUM_EN
                        chksum_d  = 32'd0;
`endif
                        state_d   = SEL;
                    end
                end
                SEL: begin
                    if (cnt_q == 4'd0) state_d = CAP;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                CAP: begin
                    out_data_d  = reg_data;
                    out_idx_d   = {1'b0, reg_sel_q};
                    out_valid_d = 1'b1;
`ifdef REGDUMP_CHKSUM_EN
                    out_last_d  = 1'b0;
`else
                    out_last_d  = (reg_sel_q == LAST_SEL);
`endif
                    state_d     = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
`ifdef REGDUMP_CHKSUM_EN
                        chksum_d    = chksum_q ^ out_data_q;
`endif
                        if (reg_sel_q < LAST_SEL) begin
                            reg_sel_d = reg_sel_q + 5'd1;
                            cnt_d     = SETTLE_LD;
                            state_d   = SEL;
                        end else begin
`ifdef REGDUMP_CHKSUM_EN
                            state_d   = CHK;
`else
                            state_d   = IDLE;
                            done_d    = 1'b1;
`endif
                        end
                    end
                end
`ifdef REGDUMP_CHKSUM_EN
                // one idle cycle after the last register word keeps words non back-to-back
                CHK: begin
                    if (!out_valid_q) begin
                        out_data_d  = chksum_q;
                        out_idx_d   = 6'h20;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            reg_sel_q   <= 5'd0;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_idx_q   <= 6'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGDUMP_CHKSUM_EN
            chksum_q    <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            reg_sel_q   <= reg_sel_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGDUMP_CHKSUM_EN
            chksum_q    <= chksum_d;
`endif
        end
    end

    assign reg_sel   = reg_sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
